// File: rtl/fpu_dispatch_if.sv
// Core/FPU-facing bus of the FPU dispatch block.
// master = environment side (core + FPU), slave = the dispatcher itself.
interface fpu_dispatch_if;
  // Core command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_inst;
  logic [31:0] cmd_data;

  // FPU issue channel
  logic [4:0]  fpu_x1;
  logic [4:0]  fpu_x2;
  logic [4:0]  fpu_y;
  logic [5:0]  fpu_operation;
  logic [31:0] fpu_in_data;
  logic        fpu_ready;
  logic        fpu_valid;
  logic        fpu_out_data1;
  logic [31:0] fpu_out_data32;

  // Result channel back to the core
  logic        res_valid;
  logic        res_data1;
  logic [31:0] res_data32;
  logic        res_illegal;
  logic        err_timeout;

  modport master (
    output cmd_valid, cmd_inst, cmd_data,
    output fpu_valid, fpu_out_data1, fpu_out_data32,
    input  cmd_ready,
    input  fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data, fpu_ready,
    input  res_valid, res_data1, res_data32, res_illegal, err_timeout
  );

  modport slave (
    input  cmd_valid, cmd_inst, cmd_data,
    input  fpu_valid, fpu_out_data1, fpu_out_data32,
    output cmd_ready,
    output fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data, fpu_ready,
    output res_valid, res_data1, res_data32, res_illegal, err_timeout
  );
endinterface

// File: rtl/fpu_dispatch.sv
// FPU dispatch: buffers decoded FPU commands from the core in a small FIFO
// and issues them one at a time over the FPU ready/valid handshake. Operands
// are held stable until the FPU completes; the result returns to the core
// as a one-cycle pulse. Unknown opcodes and hung FPU operations complete
// with res_illegal set instead of stalling the core.
module fpu_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rstn,
  fpu_dispatch_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // GET only reads the FPU register file, so it is the one safe idle opcode.
  localparam logic [5:0] OP_GET = 6'b111111;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b000101, 6'b000110, 6'b010000,
      6'b100000, 6'b101000, 6'b111000, 6'b111001, 6'b111101, 6'b111110,
      6'b111111: op_legal = 1'b1;
      default:   op_legal = 1'b0;
    endcase
  endfunction

  // Command FIFO: only inst[31:11] carries meaning, the low bits are dropped.
  logic [20:0] mem_inst [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  logic [1:0]    state;
  logic [CW-1:0] tmo_cnt;

  logic          issue_ready;
  logic [5:0]    issue_op;
  logic [4:0]    issue_y;
  logic [4:0]    issue_x1;
  logic [4:0]    issue_x2;
  logic [31:0]   issue_data;

  logic          res_d1;
  logic [31:0]   res_d32;
  logic          res_ill;
  logic          err_tmo;

  logic [20:0]   head_inst;
  logic [31:0]   head_data;
  logic [5:0]    head_op;
  logic          unused_inst_bits;

  assign unused_inst_bits = ^bus.cmd_inst[10:0];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state == S_IDLE) && !empty;

  assign head_inst = mem_inst[rd_ptr[AW-1:0]];
  assign head_data = mem_data[rd_ptr[AW-1:0]];
  assign head_op   = head_inst[20:15];

  // FIFO storage writes on every accepted push.
  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr[AW-1:0]] <= bus.cmd_inst[31:11];
      mem_data[wr_ptr[AW-1:0]] <= bus.cmd_data;
    end
  end

  // FIFO pointers advance on push and pop; reset drops all queued commands.
  // NOTE: sequential state always uses non-blocking assignments so every
  // block sees pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Dispatch FSM: pop in IDLE, hold the FPU strobe in ISSUE, pulse in DONE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      issue_ready <= 1'b0;
      issue_op    <= OP_GET;
      issue_y     <= '0;
      issue_x1    <= '0;
      issue_x2    <= '0;
      issue_data  <= '0;
      res_d1      <= 1'b0;
      res_d32     <= '0;
      res_ill     <= 1'b0;
      err_tmo     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            if (op_legal(head_op)) begin
              state       <= S_ISSUE;
              tmo_cnt     <= '0;
              issue_ready <= 1'b1;
              issue_op    <= head_op;
              issue_y     <= head_inst[14:10];
              issue_x1    <= head_inst[9:5];
              issue_x2    <= head_inst[4:0];
              issue_data  <= head_data;
            end else begin
              // Unknown opcode: complete without ever strobing the FPU.
              state   <= S_DONE;
              res_ill <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // Completion wins over an abort landing on the same cycle.
          if (bus.fpu_valid) begin
            state       <= S_DONE;
            res_d1      <= bus.fpu_out_data1;
            res_d32     <= bus.fpu_out_data32;
            res_ill     <= 1'b0;
            issue_ready <= 1'b0;
            issue_op    <= OP_GET;
            issue_y     <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= S_DONE;
            res_ill     <= 1'b1;
            err_tmo     <= 1'b1;
            issue_ready <= 1'b0;
            issue_op    <= OP_GET;
            issue_y     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = !full;
  assign bus.fpu_ready     = issue_ready;
  assign bus.fpu_operation = issue_op;
  assign bus.fpu_y         = issue_y;
  assign bus.fpu_x1        = issue_x1;
  assign bus.fpu_x2        = issue_x2;
  assign bus.fpu_in_data   = issue_data;
  assign bus.res_valid     = (state == S_DONE);
  assign bus.res_data1     = res_d1;
  assign bus.res_data32    = res_d32;
  assign bus.res_illegal   = res_ill;
  assign bus.err_timeout   = err_tmo;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch: directed commands against a small FPU model.
// Expected results go into a scoreboard queue at push time; a monitor
// compares them whenever res_valid shows, and checks issue traffic.
module tb_fpu_dispatch;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  fpu_dispatch_if bus ();

  fpu_dispatch #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic        illegal;
    logic        chk;
    logic        d1;
    logic [31:0] d32;
  } res_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  y;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [31:0] data;
  } iss_t;

  res_t exp_q[$];
  iss_t iss_q[$];

  int total = 0;
  int bad   = 0;
  int rdy_cycles = 0;
  int res_seen   = 0;

  // FPU model: register file read combinationally, per-opcode latency.
  logic [31:0] rf [32];
  logic        fpu_dead = 1'b0;
  int          busy_cnt = 0;

  function automatic int lat_of(input logic [5:0] op);
    case (op)
      6'b000010:            return 5;  // FMUL
      6'b000000, 6'b000001: return 2;  // FADD, FSUB
      default:              return 0;
    endcase
  endfunction

  assign bus.fpu_valid      = bus.fpu_ready && !fpu_dead && (busy_cnt == lat_of(bus.fpu_operation));
  assign bus.fpu_out_data32 = rf[bus.fpu_x1];
  assign bus.fpu_out_data1  = ($signed(rf[bus.fpu_x1]) < $signed(rf[bus.fpu_x2]));

  always @(posedge clk) begin
    if (!bus.fpu_ready || bus.fpu_valid) busy_cnt <= 0;
    else                                 busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: issue operands, idle opcode rule and result scoreboard.
  initial begin
    logic rdy_prev;
    iss_t cur;
    res_t e;
    rdy_prev = 1'b0;
    cur = '{op: 6'h3F, y: 5'd0, x1: 5'd0, x2: 5'd0, data: 32'd0};
    forever begin
      @(negedge clk);
      if (!rstn) begin
        rdy_prev = 1'b0;
      end else begin
        if (bus.fpu_ready) begin
          rdy_cycles++;
          if (!rdy_prev) begin
            if (iss_q.size() == 0) check("unexpected_issue", 1, 0);
            else cur = iss_q.pop_front();
          end
          check("issue_op",   bus.fpu_operation, cur.op);
          check("issue_y",    bus.fpu_y,         cur.y);
          check("issue_x1",   bus.fpu_x1,        cur.x1);
          check("issue_x2",   bus.fpu_x2,        cur.x2);
          check("issue_data", bus.fpu_in_data,   cur.data);
        end else begin
          check("idle_op_y", {bus.fpu_operation, bus.fpu_y}, {6'h3F, 5'd0});
        end
        rdy_prev = bus.fpu_ready;
        if (bus.res_valid) begin
          res_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_res", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("res_illegal", bus.res_illegal, e.illegal);
            if (e.chk) begin
              check("res_data32", bus.res_data32, e.d32);
              check("res_data1",  bus.res_data1,  e.d1);
            end
          end
        end
      end
    end
  end

  // Offer one command; called and returns at a negedge.
  task automatic push(input logic [5:0] op, input logic [4:0] y, input logic [4:0] x1,
                      input logic [4:0] x2, input logic [31:0] d, input logic issued,
                      input logic illegal, input logic chk, input logic d1,
                      input logic [31:0] d32, output logic waited);
    int   g;
    res_t r;
    iss_t s;
    g = 0;
    waited = 1'b0;
    while (!bus.cmd_ready && g < 100) begin
      waited = 1'b1;
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("push_wait_bound", 0, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_inst  = {op, y, x1, x2, 11'h5A5};
    bus.cmd_data  = d;
    r.illegal = illegal; r.chk = chk; r.d1 = d1; r.d32 = d32;
    exp_q.push_back(r);
    if (issued) begin
      s.op = op; s.y = y; s.x1 = x1; s.x2 = x2; s.data = d;
      iss_q.push_back(s);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.fpu_ready || bus.res_valid) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check({name, "_drain"}, 32'(g < 200), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w;
    logic w5;
    logic w6;
    int   n;
    int   r0;
    int   s0;

    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[2] = 32'h4000_0000;
    rf[3] = 32'h3F80_0000;
    rf[4] = 32'hFFFF_FFFF;
    rf[5] = 32'h0000_0001;
    rf[6] = 32'hDEAD_BEEF;
    rf[7] = 32'h0000_0007;
    rf[8] = 32'hA5A5_A5A5;
    rf[9] = 32'h5A5A_5A5A;

    bus.cmd_valid = 1'b0;
    bus.cmd_inst  = '0;
    bus.cmd_data  = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_cmd_ready",   bus.cmd_ready,     1);
    check("rst_fpu_ready",   bus.fpu_ready,     0);
    check("rst_fpu_op",      bus.fpu_operation, 32'h3F);
    check("rst_fpu_idx",     {bus.fpu_x1, bus.fpu_x2, bus.fpu_y}, 0);
    check("rst_fpu_in_data", bus.fpu_in_data,   0);
    check("rst_res_valid",   bus.res_valid,     0);
    check("rst_res_data",    {bus.res_data1, bus.res_illegal}, 0);
    check("rst_res_data32",  bus.res_data32,    0);
    check("rst_err_timeout", bus.err_timeout,   0);
    rstn = 1'b1;
    @(negedge clk);

    // GET x1=3: single-cycle op, result two cycles after push
    r0 = rdy_cycles;
    push(6'b111111, 5'd0, 5'd3, 5'd0, 32'd0, 1, 0, 1, 0, 32'h3F80_0000, w);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("get_latency", n, 2);
    drain("get");
    check("get_ready_cycles", rdy_cycles - r0, 1);
    check("get_res_hold", bus.res_data32, 32'h3F80_0000);

    // FADD y=1 x1=2 x2=3 with a 3-cycle FPU
    r0 = rdy_cycles;
    push(6'b000000, 5'd1, 5'd2, 5'd3, 32'd0, 1, 0, 1, 0, 32'h4000_0000, w);
    drain("fadd");
    check("fadd_ready_cycles", rdy_cycles - r0, 3);
    check("fadd_op_after", bus.fpu_operation, 32'h3F);

    // FCLT compare bit, ITOF operand passthrough
    push(6'b100000, 5'd0, 5'd4, 5'd5, 32'd0,          1, 0, 1, 1, 32'hFFFF_FFFF, w);
    push(6'b111001, 5'd10, 5'd0, 5'd0, 32'h1234_5678, 1, 0, 1, 0, 32'h0000_0000, w);
    drain("fclt_itof");

    // Six back-to-back commands while the first (FMUL) stalls: FIFO fills and wraps
    s0 = res_seen;
    push(6'b000010, 5'd2, 5'd6, 5'd7, 32'd0, 1, 0, 1, 1, 32'hDEAD_BEEF, w);
    push(6'b111111, 5'd0, 5'd7, 5'd0, 32'd0, 1, 0, 1, 0, 32'h0000_0007, w);
    push(6'b111111, 5'd0, 5'd8, 5'd9, 32'd0, 1, 0, 1, 1, 32'hA5A5_A5A5, w);
    push(6'b111111, 5'd0, 5'd9, 5'd8, 32'd0, 1, 0, 1, 0, 32'h5A5A_5A5A, w);
    push(6'b111111, 5'd0, 5'd3, 5'd9, 32'd0, 1, 0, 1, 1, 32'h3F80_0000, w5);
    push(6'b111111, 5'd0, 5'd2, 5'd4, 32'd0, 1, 0, 1, 0, 32'h4000_0000, w6);
    check("fifo_not_full_at_4", w5, 0);
    check("fifo_full_stall",    w6, 1);
    drain("burst");
    check("burst_results", res_seen - s0, 6);

    // Illegal opcode: completes with res_illegal, no FPU strobe
    r0 = rdy_cycles;
    push(6'b000011, 5'd1, 5'd2, 5'd3, 32'd0, 0, 1, 0, 0, 32'd0, w);
    drain("illegal");
    check("illegal_no_ready", rdy_cycles - r0, 0);

    // Hung FPU: abort after 8 ISSUE cycles, sticky error
    check("tmo_err_before", bus.err_timeout, 0);
    fpu_dead = 1'b1;
    r0 = rdy_cycles;
    push(6'b000000, 5'd1, 5'd2, 5'd3, 32'd0, 1, 1, 0, 0, 32'd0, w);
    drain("timeout");
    check("tmo_ready_cycles", rdy_cycles - r0, 8);
    check("tmo_err_set", bus.err_timeout, 1);
    fpu_dead = 1'b0;
    push(6'b111111, 5'd0, 5'd9, 5'd0, 32'd0, 1, 0, 1, 0, 32'h5A5A_5A5A, w);
    drain("after_tmo");
    check("tmo_err_sticky", bus.err_timeout, 1);

    // Reset during FMUL ISSUE with two commands queued
    push(6'b000010, 5'd2, 5'd6, 5'd7, 32'd0, 1, 0, 1, 1, 32'hDEAD_BEEF, w);
    push(6'b111111, 5'd0, 5'd7, 5'd0, 32'd0, 1, 0, 1, 0, 32'h0000_0007, w);
    push(6'b111111, 5'd0, 5'd8, 5'd9, 32'd0, 1, 0, 1, 1, 32'hA5A5_A5A5, w);
    check("mid_issue_ready", bus.fpu_ready, 1);
    rstn = 1'b0;
    exp_q.delete();
    iss_q.delete();
    @(negedge clk);
    check("mid_rst_fpu_ready", bus.fpu_ready, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_fpu_op",    bus.fpu_operation, 32'h3F);
    check("mid_rst_err",       bus.err_timeout, 0);
    rstn = 1'b1;
    r0 = rdy_cycles;
    s0 = res_seen;
    repeat (12) @(negedge clk);
    check("mid_rst_no_issue", rdy_cycles - r0, 0);
    check("mid_rst_no_res",   res_seen - s0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
